inst_mem_resp: RTL and testbench

INST_MEM_RESP -- requirements
Module: inst_mem_resp

---
 rtl/inst_mem_resp_if.sv | 24 ++
 rtl/inst_mem_resp.sv | 97 +++++++++
 tb/tb_inst_mem_resp.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/inst_mem_resp_if.sv
// Fetch/loader bus between the PC side (master) and the instruction memory (slave).
interface inst_mem_resp_if;
   logic [31:0] ins_addr;
   logic        inst_ce;
   logic        ld_we;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        ld_done;
   logic [31:0] inst;
   logic        inst_valid;
   logic        addr_err;
   logic [1:0]  state;
   logic [15:0] fetch_cnt;

   modport master (
      output ins_addr, inst_ce, ld_we, ld_addr, ld_data, ld_done,
      input  inst, inst_valid, addr_err, state, fetch_cnt
   );

   modport slave (
      input  ins_addr, inst_ce, ld_we, ld_addr, ld_data, ld_done,
      output inst, inst_valid, addr_err, state, fetch_cnt
   );
endinterface

// File: rtl/inst_mem_resp.sv
// Loadable instruction memory with one-cycle registered fetch response.
// Optional macro INST_MEM_BOUND_CHK_EN rejects addresses beyond DEPTH words.
module inst_mem_resp #(
   parameter int DEPTH = 64
) (
   input logic           clk,
   input logic           RST,
   inst_mem_resp_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      LOAD = 2'b00,
      RUN  = 2'b01
   } state_e;

   state_e state_q, state_d;

   logic [31:0] mem_q [DEPTH];

   logic [31:0] inst_q, inst_d;
   logic        vld_q, vld_d;
   logic        err_q, err_d;
   logic [15:0] cnt_q, cnt_d;

   logic [AW-1:0] rd_idx, wr_idx;
   logic          rd_mis, rd_oob, wr_oob, wr_en;

   assign rd_idx = bus.ins_addr[AW+1:2];
   assign wr_idx = bus.ld_addr[AW+1:2];
   assign rd_mis = |bus.ins_addr[1:0];

`ifdef INST_MEM_BOUND_CHK_EN
   assign rd_oob = |bus.ins_addr[31:AW+2];
   assign wr_oob = |bus.ld_addr[31:AW+2];
`else
   // Upper address bits are don't-care: the index simply wraps modulo DEPTH.
   assign rd_oob = 1'b0;
   assign wr_oob = 1'b0;
`endif

   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.ins_addr[31:AW+2], bus.ld_addr[31:AW+2], bus.ld_addr[1:0]};

   // State register
   always_ff @(posedge clk or posedge RST) begin
      if (RST) state_q <= LOAD;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    if (bus.ld_done) state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = LOAD;
      endcase
   end

   // Storage has no reset so loaded code survives RST.
   assign wr_en = (state_q == LOAD) && bus.ld_we && !wr_oob;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= bus.ld_data;
   end

   always_comb begin
      vld_d  = (state_q == RUN) && bus.inst_ce;
      err_d  = vld_d && (rd_mis || rd_oob);
      inst_d = inst_q;
      cnt_d  = cnt_q;
      if (vld_d) begin
         inst_d = err_d ? 32'h0 : mem_q[rd_idx];
         if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         inst_q <= 32'h0;
         vld_q  <= 1'b0;
         err_q  <= 1'b0;
         cnt_q  <= 16'h0;
      end else begin
         inst_q <= inst_d;
         vld_q  <= vld_d;
         err_q  <= err_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.inst       = inst_q;
   assign bus.inst_valid = vld_q;
   assign bus.addr_err   = err_q;
   assign bus.state      = state_q;
   assign bus.fetch_cnt  = cnt_q;
endmodule

// File: tb/tb_inst_mem_resp.sv
// Directed, table-driven check of inst_mem_resp (DEPTH=64).
module tb_inst_mem_resp;
   logic clk = 1'b0;
   logic RST = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   inst_mem_resp_if bus ();

   inst_mem_resp #(.DEPTH(64)) dut (
      .clk (clk),
      .RST (RST),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ce;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] inst;
      logic        err;
      logic [15:0] cnt;
   } vec_t;

   vec_t vt [14];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_resp(input string nm, input logic vld, input logic [31:0] inst, input logic err);
      chk({nm, "_vld"}, {31'h0, bus.inst_valid}, {31'h0, vld});
      chk({nm, "_inst"}, bus.inst, inst);
      chk({nm, "_err"}, {31'h0, bus.addr_err}, {31'h0, err});
   endtask

   initial begin
      // Fetch-side vectors run after words 0..5 are loaded; fetch_cnt is
      // compared on idle rows only.
      vt[0]  = '{1'b1, 32'h00, 1'b1, 32'h11110000, 1'b0, 16'd0};
      vt[1]  = '{1'b1, 32'h04, 1'b1, 32'h11110001, 1'b0, 16'd0};
      vt[2]  = '{1'b1, 32'h08, 1'b1, 32'h11110002, 1'b0, 16'd0};
      vt[3]  = '{1'b1, 32'h0C, 1'b1, 32'h11110003, 1'b0, 16'd0};
      vt[4]  = '{1'b1, 32'h10, 1'b1, 32'h11110004, 1'b0, 16'd0};
      vt[5]  = '{1'b1, 32'h14, 1'b1, 32'h11110005, 1'b0, 16'd0};
      vt[6]  = '{1'b1, 32'h00, 1'b1, 32'h11110000, 1'b0, 16'd0};
      vt[7]  = '{1'b0, 32'h00, 1'b0, 32'h11110000, 1'b0, 16'd7};
      vt[8]  = '{1'b1, 32'h02, 1'b1, 32'h00000000, 1'b1, 16'd0};
      vt[9]  = '{1'b0, 32'h00, 1'b0, 32'h00000000, 1'b0, 16'd8};
`ifdef INST_MEM_BOUND_CHK_EN
      vt[10] = '{1'b1, 32'h100, 1'b1, 32'h00000000, 1'b1, 16'd0};
`else
      vt[10] = '{1'b1, 32'h100, 1'b1, 32'h11110000, 1'b0, 16'd0};
`endif
      vt[11] = '{1'b1, 32'h17, 1'b1, 32'h00000000, 1'b1, 16'd0};
      vt[12] = '{1'b1, 32'h14, 1'b1, 32'h11110005, 1'b0, 16'd0};
      vt[13] = '{1'b0, 32'h00, 1'b0, 32'h11110005, 1'b0, 16'd11};

      bus.ins_addr = 32'h0;
      bus.inst_ce  = 1'b0;
      bus.ld_we    = 1'b0;
      bus.ld_addr  = 32'h0;
      bus.ld_data  = 32'h0;
      bus.ld_done  = 1'b0;

      #1 RST = 1'b1;
      #1;
      chk_resp("rst", 1'b0, 32'h0, 1'b0);
      chk("rst_state", {30'h0, bus.state}, 32'h0);
      chk("rst_cnt", {16'h0, bus.fetch_cnt}, 32'h0);
      #1 RST = 1'b0;

      // Fetch requests while loading are ignored.
      bus.inst_ce = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("load_ce%0d_vld", i), {31'h0, bus.inst_valid}, 32'h0);
         chk($sformatf("load_ce%0d_cnt", i), {16'h0, bus.fetch_cnt}, 32'h0);
         chk($sformatf("load_ce%0d_state", i), {30'h0, bus.state}, 32'h0);
      end
      bus.inst_ce = 1'b0;

      for (int i = 0; i < 6; i++) begin
         bus.ld_we   = 1'b1;
         bus.ld_addr = 32'(i * 4);
         bus.ld_data = 32'h11110000 + 32'(i);
         step();
      end
      bus.ld_we   = 1'b0;
      bus.ld_done = 1'b1;
      step();
      bus.ld_done = 1'b0;
      chk("run_state", {30'h0, bus.state}, 32'h1);

      for (int i = 0; i < 14; i++) begin
         bus.inst_ce  = vt[i].ce;
         bus.ins_addr = vt[i].addr;
         step();
         chk_resp($sformatf("v%0d", i), vt[i].vld, vt[i].inst, vt[i].err);
         if (!vt[i].ce)
            chk($sformatf("v%0d_cnt", i), {16'h0, bus.fetch_cnt}, {16'h0, vt[i].cnt});
      end

      // Loader writes in RUN must not reach memory.
      bus.ld_we    = 1'b1;
      bus.ld_addr  = 32'h4;
      bus.ld_data  = 32'h00000BAD;
      bus.inst_ce  = 1'b1;
      bus.ins_addr = 32'h4;
      step();
      bus.ld_we = 1'b0;
      chk_resp("runwr_a", 1'b1, 32'h11110001, 1'b0);
      step();
      chk_resp("runwr_b", 1'b1, 32'h11110001, 1'b0);

      // Asynchronous reset between edges with a request in flight.
      bus.ins_addr = 32'h8;
      #3 RST = 1'b1;
      #1;
      chk_resp("arst", 1'b0, 32'h0, 1'b0);
      chk("arst_state", {30'h0, bus.state}, 32'h0);
      chk("arst_cnt", {16'h0, bus.fetch_cnt}, 32'h0);
      #2 RST = 1'b0;
      step();
      chk("rel_state", {30'h0, bus.state}, 32'h0);
      chk("rel_vld", {31'h0, bus.inst_valid}, 32'h0);

      // Same-cycle write and ld_done; the first RUN read must see it.
      bus.ld_we   = 1'b1;
      bus.ld_addr = 32'h0;
      bus.ld_data = 32'hDEADBEEF;
      bus.ld_done = 1'b1;
      step();
      bus.ld_we   = 1'b0;
      bus.ld_done = 1'b0;
      chk("same_state", {30'h0, bus.state}, 32'h1);
      chk("same_vld", {31'h0, bus.inst_valid}, 32'h0);
      bus.ins_addr = 32'h0;
      step();
      chk_resp("same_rd", 1'b1, 32'hDEADBEEF, 1'b0);
      bus.ins_addr = 32'h8;
      step();
      chk_resp("keep_w2", 1'b1, 32'h11110002, 1'b0);
      bus.ins_addr = 32'h14;
      step();
      chk_resp("keep_w5", 1'b1, 32'h11110005, 1'b0);
      bus.inst_ce = 1'b0;
      step();
      chk_resp("post_idle", 1'b0, 32'h11110005, 1'b0);
      chk("post_cnt", {16'h0, bus.fetch_cnt}, 32'd3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
